// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit: load/store/fetch requests -> word-wide variable-latency   |
// | RAM port, with lane steering, load extension and done/error handshake.     |
// | Optional: define MEM_TIMEOUT_EN for a REQ-state bus-error timeout.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_fetch,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              req_err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_write;
  logic              r_err;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic [2:0]        w_f3;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_bad;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_lane;
  logic [31:0]       w_ext;
  logic              w_timeout;

  // A fetch is treated as lw so the rest of the datapath needs no fetch flag.
  assign w_f3 = req_fetch ? 3'b010 : req_funct3;

  always_comb begin
    w_illegal = 1'b0;
    if (!req_fetch) begin
      if (req_write)
        w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      else
        w_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    end
  end

  always_comb begin
    case (w_f3[1:0])
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = (req_addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_bad = w_illegal || w_misalign;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    if (req_write) begin
      case (req_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << req_addr[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: w_wdata = req_wdata;
      endcase
    end
  end

  assign w_lane = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (r_state != S_REQ)
      r_cnt <= '0;
    else if (!mem_ack)
      r_cnt <= r_cnt + 1'b1;
  end

  // Gated by !mem_ack so an ack landing on the timeout cycle still completes.
  assign w_timeout = (r_state == S_REQ) && !mem_ack &&
                     (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_bad ? S_RESP : S_REQ;
      S_REQ:   if (mem_ack || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_funct3 <= 3'd0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_addr   <= req_addr;
        r_funct3 <= w_f3;
        r_write  <= req_write;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_err    <= w_bad;
      end
      if (r_state == S_REQ && mem_ack && !r_write)
        r_rdata <= w_ext;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign mem_en    = (r_state == S_REQ);
  assign mem_we    = mem_en && r_write;
  assign mem_be    = r_be;
  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = r_wdata;
  assign req_ready = (r_state == S_RESP);
  assign req_err   = (r_state == S_RESP) && r_err;
  assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit: directed vector table plus hand-written sequences.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_fetch = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        req_err;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h5A5A5A5A;
  logic        mem_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_fetch(req_fetch),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_err(req_err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        fe;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdx;
    logic [31:0] rdx;
  } vec_t;

  vec_t tbl[20];

  task automatic run(input vec_t v, input string name);
    int lat;
    int en;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_fetch  = v.fe;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wd;
    @(posedge clk); #1;
    lat = 1;
    en  = 0;
    while (!req_ready && lat < 40) begin
      if (mem_en) begin
        en++;
        check({name, " bus"}, {mem_we, mem_be, mem_addr},
              {v.wr, v.be, v.addr[31:2], 2'b00});
        if (v.wr) check({name, " wdata"}, mem_wdata, v.wdx);
        if (en == v.dly) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rd;
        end
      end
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A5A5A;
      lat++;
    end
    req_valid = 1'b0;
    check({name, " latency"}, 96'(lat), v.err ? 96'd1 : 96'(v.dly + 1));
    check({name, " en_cycles"}, 96'(en), v.err ? 96'd0 : 96'(v.dly));
    check({name, " err"}, req_err, v.err);
    check({name, " rdata"}, rdata, v.rdx);
    @(posedge clk); #1;
    check({name, " ready_pulse"}, req_ready, 1'b0);
  endtask

  initial begin
    //          wr    fe    f3      addr          wd            rd            dly err   be       wdx           rdx
    tbl[0]  = '{1'b0, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1'b0, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b0, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 2, 1'b0, 4'b1111, 32'h0,        32'h00000080};
    tbl[3]  = '{1'b0, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 1, 1'b0, 4'b1111, 32'h0,        32'h000080FF};
    tbl[4]  = '{1'b0, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 3, 1'b0, 4'b1111, 32'h0,        32'hFFFF80FF};
    tbl[5]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h123456AB, 32'h0,        1, 1'b0, 4'b0100, 32'hABABABAB, 32'hFFFF80FF};
    tbl[6]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'hDEAD1234, 32'h0,        2, 1'b0, 4'b1100, 32'h12341234, 32'hFFFF80FF};
    tbl[7]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0,        1, 1'b0, 4'b1111, 32'hCAFEF00D, 32'hFFFF80FF};
    tbl[8]  = '{1'b0, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'hFFFF80FF};
    tbl[9]  = '{1'b0, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'hFFFF80FF};
    tbl[10] = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'hFFFF80FF};
    tbl[11] = '{1'b1, 1'b0, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'hFFFF80FF};
    tbl[12] = '{1'b0, 1'b0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'hFFFF80FF};
    tbl[13] = '{1'b0, 1'b1, 3'b001, 32'h200, 32'h0,        32'h12345678, 5, 1'b0, 4'b1111, 32'h0,        32'h12345678};
    tbl[14] = '{1'b0, 1'b1, 3'b000, 32'h202, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h12345678};
    tbl[15] = '{1'b0, 1'b0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 1, 1'b0, 4'b1111, 32'h0,        32'h0000007F};
    tbl[16] = '{1'b0, 1'b0, 3'b001, 32'h100, 32'h0,        32'h00008001, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFF8001};
    tbl[17] = '{1'b0, 1'b0, 3'b101, 32'h100, 32'h0,        32'h00008001, 2, 1'b0, 4'b1111, 32'h0,        32'h00008001};
    tbl[18] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'hFFFFFF5C, 32'h0,        1, 1'b0, 4'b0010, 32'h5C5C5C5C, 32'h00008001};
    tbl[19] = '{1'b0, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00008001, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF80};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {req_ready, req_err, rdata, mem_en, mem_we, mem_be, mem_addr, mem_wdata},
          96'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++)
      run(tbl[i], $sformatf("vec%0d", i));

    // mem_ack while idle must be ignored
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h11111111;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ack ready", {req_ready, mem_en}, 2'b00);
    check("idle_ack rdata", rdata, 32'hFFFFFF80);
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A5A5A;

    // No ack at all: timeout build gives up, default build keeps waiting
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_fetch  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
    begin
      int en = 0;
      int guard = 0;
      while (!req_ready && guard < 40) begin
        if (mem_en) en++;
        @(posedge clk); #1;
        guard++;
      end
      check("timeout en_cycles", 96'(en), 96'd4);
      check("timeout ready_err", {req_ready, req_err, mem_en}, 3'b110);
      check("timeout rdata", rdata, 32'hFFFFFF80);
      @(posedge clk); #1;
    end
`else
    repeat (19) @(posedge clk);
    #1;
    check("no_timeout wait20", {mem_en, req_ready}, 2'b10);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A5A5A;
    check("no_timeout done", {req_ready, req_err}, 2'b10);
    check("no_timeout rdata", rdata, 32'h0BADF00D);
    @(posedge clk); #1;
`endif

    // Reset asserted mid-REQ
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    check("pre_reset en", mem_en, 1'b1);
    @(negedge clk);
    rst     = 1'b0;
    mem_ack = 1'b1;
    #1;
    check("async_reset outputs", {mem_en, req_ready, rdata, mem_be}, 37'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset idle", {mem_en, req_ready}, 2'b00);
    mem_ack = 1'b0;
    run(tbl[0], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
